// File: rtl/uart_tx_sched_if.sv
// Handshake bundle between the requesters/frame engine and uart_tx_sched.
// The scheduler uses the slave view; clients and engine drive the master view.
interface uart_tx_sched_if #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 8
);
   localparam int OW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic [NUM_REQ-1:0]            REQ;
   logic [NUM_REQ*DATA_WIDTH-1:0] REQ_DATA;
   logic [NUM_REQ-1:0]            REQ_PAR;
   logic                          BUSY;
   logic [DATA_WIDTH-1:0]         TX_DATA;
   logic                          PAR_EN;
   logic                          DATA_VALID;
   logic [NUM_REQ-1:0]            GNT;
   logic [NUM_REQ-1:0]            DONE;
   logic                          ERR;
   logic [OW-1:0]                 OWNER;

   modport master (
      output REQ, REQ_DATA, REQ_PAR, BUSY,
      input  TX_DATA, PAR_EN, DATA_VALID, GNT, DONE, ERR, OWNER
   );

   modport slave (
      input  REQ, REQ_DATA, REQ_PAR, BUSY,
      output TX_DATA, PAR_EN, DATA_VALID, GNT, DONE, ERR, OWNER
   );
endinterface

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one UART TX frame engine among NUM_REQ clients.
// state      | meaning
// S_IDLE     | arbitrate when engine idle and any REQ set
// S_ISSUE    | DATA_VALID and GNT[w] visible for exactly one cycle
// S_WAIT_START | wait for BUSY rise, ERR after TO_CYCLES without it
// S_WAIT_END | wait for BUSY fall, then DONE[w]
module uart_tx_sched #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 8,
   parameter int TO_CYCLES  = 16
) (
   input logic             CLK,
   input logic             RST,
   uart_tx_sched_if.slave  bus
);
   localparam int OW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CW = (TO_CYCLES > 2) ? $clog2(TO_CYCLES) : 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT_START,
      S_WAIT_END
   } state_t;

   state_t                  state_q;
   logic [OW-1:0]           ptr_q;
   logic [OW-1:0]           owner_q;
   logic [CW-1:0]           cnt_q;
   logic [DATA_WIDTH-1:0]   tx_data_q;
   logic                    par_en_q;
   logic                    dv_q;
   logic [NUM_REQ-1:0]      gnt_q;
   logic [NUM_REQ-1:0]      done_q;
   logic                    err_q;

   logic                    win_vld_d;
   logic [OW-1:0]           win_d;
   logic [OW-1:0]           ptr_nxt_d;

   // Scan downward so the last hit is the one closest to the pointer.
   always_comb begin
      win_vld_d = 1'b0;
      win_d     = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         int idx;
         idx = int'(ptr_q) + i;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         if (bus.REQ[idx]) begin
            win_vld_d = 1'b1;
            win_d     = OW'(idx);
         end
      end
   end

   assign ptr_nxt_d = (owner_q == OW'(NUM_REQ - 1)) ? '0 : owner_q + OW'(1);

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q   <= S_IDLE;
         ptr_q     <= '0;
         owner_q   <= '0;
         cnt_q     <= '0;
         tx_data_q <= '0;
         par_en_q  <= 1'b0;
         dv_q      <= 1'b0;
         gnt_q     <= '0;
         done_q    <= '0;
         err_q     <= 1'b0;
      end else begin
         dv_q   <= 1'b0;
         gnt_q  <= '0;
         done_q <= '0;
         err_q  <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (win_vld_d && !bus.BUSY) begin
                  tx_data_q <= bus.REQ_DATA[win_d*DATA_WIDTH +: DATA_WIDTH];
                  par_en_q  <= bus.REQ_PAR[win_d];
                  owner_q   <= win_d;
                  gnt_q     <= NUM_REQ'(1) << win_d;
                  dv_q      <= 1'b1;
                  state_q   <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               cnt_q   <= '0;
               state_q <= S_WAIT_START;
            end
            S_WAIT_START: begin
               if (bus.BUSY) begin
                  state_q <= S_WAIT_END;
               end else begin
                  cnt_q <= cnt_q + CW'(1);
                  // counter is about to reach TO_CYCLES-1: give up on this frame
                  if (cnt_q == CW'(TO_CYCLES - 2)) begin
                     err_q   <= 1'b1;
                     ptr_q   <= ptr_nxt_d;
                     state_q <= S_IDLE;
                  end
               end
            end
            S_WAIT_END: begin
               if (!bus.BUSY) begin
                  done_q  <= NUM_REQ'(1) << owner_q;
                  ptr_q   <= ptr_nxt_d;
                  state_q <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign bus.TX_DATA    = tx_data_q;
   assign bus.PAR_EN     = par_en_q;
   assign bus.DATA_VALID = dv_q;
   assign bus.GNT        = gnt_q;
   assign bus.DONE       = done_q;
   assign bus.ERR        = err_q;
   assign bus.OWNER      = owner_q;
endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched: grants, round-robin order, timeout, BUSY gating, reset abort.
module tb_uart_tx_sched;
   localparam int NR = 4;
   localparam int DW = 8;
   localparam int TO = 16;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   checks = 0;
   int   errors = 0;

   uart_tx_sched_if #(.NUM_REQ(NR), .DATA_WIDTH(DW)) bus ();

   uart_tx_sched #(.NUM_REQ(NR), .DATA_WIDTH(DW), .TO_CYCLES(TO)) dut (
      .CLK (clk),
      .RST (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // {GNT, DONE, ERR, DATA_VALID}
   function automatic logic [31:0] flags();
      return {22'd0, bus.GNT, bus.DONE, bus.ERR, bus.DATA_VALID};
   endfunction

   // every output: {GNT, DONE, ERR, DATA_VALID, PAR_EN, OWNER, TX_DATA}
   function automatic logic [31:0] allout();
      return {11'd0, bus.GNT, bus.DONE, bus.ERR, bus.DATA_VALID, bus.PAR_EN, bus.OWNER, bus.TX_DATA};
   endfunction

   task automatic expect_grant(input int w, input logic [7:0] d, input logic p);
      logic [1:0] wb;
      logic [3:0] oh;
      wb = 2'(w);
      oh = 4'(1 << w);
      tick();
      chk("grant_flags", flags(), {22'd0, oh, 4'd0, 1'b0, 1'b1});
      chk("grant_payload", {21'd0, p, bus.OWNER, bus.TX_DATA} & 32'h0, 32'h0);
      chk("grant_payload_val", {21'd0, bus.PAR_EN, bus.OWNER, bus.TX_DATA}, {21'd0, p, wb, d});
   endtask

   task automatic frame(input int w, input logic [7:0] d, input int blen);
      logic [1:0] wb;
      logic [3:0] oh;
      wb = 2'(w);
      oh = 4'(1 << w);
      tick();
      chk("issue_clear", flags(), 32'd0);
      bus.BUSY = 1'b1;
      repeat (blen) begin
         tick();
         chk("busy_quiet", flags(), 32'd0);
      end
      bus.BUSY = 1'b0;
      tick();
      chk("done_flags", flags(), {22'd0, 4'd0, oh, 2'b00});
      chk("done_hold", {22'd0, bus.OWNER, bus.TX_DATA}, {22'd0, wb, d});
   endtask

   initial begin
      bus.REQ      = '0;
      bus.REQ_DATA = '0;
      bus.REQ_PAR  = '0;
      bus.BUSY     = 1'b0;

      // reset state
      repeat (2) tick();
      chk("reset_outputs", allout(), 32'd0);
      rst = 1'b1;

      // single request, parity enabled, 11-cycle frame
      bus.REQ      = 4'b0001;
      bus.REQ_DATA = 32'h0000_00A5;
      bus.REQ_PAR  = 4'b0001;
      expect_grant(0, 8'hA5, 1'b1);
      bus.REQ      = 4'b0000;
      bus.REQ_DATA = 32'hFFFF_FFFF;
      frame(0, 8'hA5, 11);

      // fresh pointer, all four requesting continuously
      rst = 1'b0;
      tick();
      chk("reset2_outputs", allout(), 32'd0);
      rst = 1'b1;
      bus.REQ      = 4'b1111;
      bus.REQ_DATA = 32'h4433_2211;
      bus.REQ_PAR  = 4'b0101;
      expect_grant(0, 8'h11, 1'b1);
      frame(0, 8'h11, 3);
      expect_grant(1, 8'h22, 1'b0);
      frame(1, 8'h22, 1);
      expect_grant(2, 8'h33, 1'b1);
      frame(2, 8'h33, 5);
      expect_grant(3, 8'h44, 1'b0);
      frame(3, 8'h44, 2);
      expect_grant(0, 8'h11, 1'b1);
      bus.REQ = 4'b0000;
      frame(0, 8'h11, 4);

      // wrap-around: pointer 1 -> grant 2, then 0101 from pointer 3 -> 0, then 0101 from 1 -> 2
      bus.REQ = 4'b0100;
      expect_grant(2, 8'h33, 1'b1);
      bus.REQ = 4'b0000;
      frame(2, 8'h33, 2);
      bus.REQ = 4'b0101;
      expect_grant(0, 8'h11, 1'b1);
      bus.REQ = 4'b0000;
      frame(0, 8'h11, 2);
      bus.REQ = 4'b0101;
      expect_grant(2, 8'h33, 1'b1);
      bus.REQ = 4'b0000;
      frame(2, 8'h33, 3);

      // start timeout: pointer 3, only requester 1 asks, engine never responds
      bus.REQ = 4'b0010;
      expect_grant(1, 8'h22, 1'b0);
      bus.REQ = 4'b0000;
      for (int i = 1; i < TO; i++) begin
         tick();
         chk("timeout_quiet", flags(), 32'd0);
      end
      tick();
      chk("timeout_err", flags(), 32'b10);
      chk("timeout_owner", {30'd0, bus.OWNER}, 32'd1);
      tick();
      chk("timeout_single", flags(), 32'd0);
      bus.REQ = 4'b1111;
      expect_grant(2, 8'h33, 1'b1);
      bus.REQ = 4'b0000;
      frame(2, 8'h33, 2);

      // BUSY held in IDLE blocks issue
      bus.BUSY = 1'b1;
      bus.REQ  = 4'b0010;
      repeat (3) begin
         tick();
         chk("busy_block", flags(), 32'd0);
      end
      bus.BUSY = 1'b0;
      expect_grant(1, 8'h22, 1'b0);
      bus.REQ = 4'b0000;
      frame(1, 8'h22, 3);

      // reset during WAIT_END aborts without DONE, pointer restarts at 0
      bus.REQ = 4'b0100;
      expect_grant(2, 8'h33, 1'b1);
      bus.REQ = 4'b0000;
      tick();
      bus.BUSY = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      #1;
      chk("async_reset", allout(), 32'd0);
      bus.BUSY = 1'b0;
      tick();
      chk("reset_no_done", allout(), 32'd0);
      bus.REQ = 4'b1000;
      rst = 1'b1;
      expect_grant(3, 8'h44, 1'b0);
      bus.REQ = 4'b0000;
      frame(3, 8'h44, 2);
      bus.REQ = 4'b1111;
      expect_grant(0, 8'h11, 1'b1);
      bus.REQ = 4'b0000;
      frame(0, 8'h11, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/uart_tx_sched.md
Name: uart_tx_sched

Overview:
Round-robin scheduler that shares one UART transmit frame engine among NUM_REQ requesters. It captures the winning requester's byte and parity-enable setting, issues a one-cycle DATA_VALID, and tracks the engine's BUSY through the whole frame. It reports completion or a start timeout back to the requester. It sits between the client blocks and the TX FSM/serializer/parity/mux datapath.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_WIDTH, 8, frame payload width
TO_CYCLES, 16, max CLK cycles to wait for BUSY rise after issue (>=2)

Ports:
CLK  in  1  clock, rising edge
RST  in  1  asynchronous active-low reset
REQ  in  NUM_REQ  per-requester request level; held until its GNT
REQ_DATA  in  NUM_REQ*DATA_WIDTH  requester i's byte at bits [i*DATA_WIDTH +: DATA_WIDTH]
REQ_PAR  in  NUM_REQ  per-requester parity enable
BUSY  in  1  frame engine busy
TX_DATA  out  DATA_WIDTH  byte to engine (registered)
PAR_EN  out  1  parity enable to engine (registered)
DATA_VALID  out  1  one-cycle frame start strobe (registered)
GNT  out  NUM_REQ  one-hot, one-cycle accept pulse
DONE  out  NUM_REQ  one-hot, one-cycle frame-complete pulse
ERR  out  1  one-cycle start-timeout pulse
OWNER  out  clog2(NUM_REQ)  index of the current or last granted requester

Behaviour:
- Reset (RST=0, async): state IDLE; TX_DATA=0, PAR_EN=0, DATA_VALID=0, GNT=0, DONE=0, ERR=0, OWNER=0. Round-robin pointer=0, so requester 0 has top priority. Timeout counter=0. Reset mid-frame aborts with no DONE/ERR. The engine is reset by the same RST.
- All outputs are registered. There are no combinational paths from inputs to outputs.
- States: IDLE, ISSUE, WAIT_START, WAIT_END.
- IDLE:
  - If REQ!=0 and BUSY=0, select the winner w: the first set REQ bit scanning from the pointer upward, with wrap-around.
  - Next edge: TX_DATA<=REQ_DATA[w], PAR_EN<=REQ_PAR[w], OWNER<=w, GNT[w]<=1, DATA_VALID<=1, state ISSUE.
  - If BUSY=1 in IDLE, do not issue; stay in IDLE.
- ISSUE (exactly 1 cycle): DATA_VALID=1 and GNT[w]=1 are visible this cycle. On exit both clear, the counter clears, and state goes to WAIT_START.
- WAIT_START:
  - If BUSY=1, go to WAIT_END.
  - Otherwise increment the counter. When the counter reaches TO_CYCLES-1 with BUSY still 0, pulse ERR for 1 cycle, advance the pointer to w+1 (mod NUM_REQ), and return to IDLE.
- WAIT_END: when BUSY=0, pulse DONE[w] for 1 cycle, set the pointer to w+1 (mod NUM_REQ), and return to IDLE.
- TX_DATA, PAR_EN and OWNER hold stable from ISSUE until the next grant, including the whole frame. REQ_DATA may change freely after GNT.
- Latency: REQ sampled in IDLE -> DATA_VALID/GNT on the next cycle. Frame end (BUSY falls) -> DONE on the next cycle. The earliest next issue is the cycle after DONE, so there is a minimum 1-cycle IDLE gap between frames.
- Simultaneous requests are resolved only by the pointer; a single requester can be granted back-to-back.
- A REQ that drops before it is granted is simply not selected; requests are never queued.
- Arbitration ignores REQ during ISSUE, WAIT_START and WAIT_END.
- GNT, DONE and ERR are never asserted in the same cycle. At most one bit of GNT or DONE is set at a time.
- The pointer changes only on DONE or ERR, never on GNT.

Test Plan:
- Reset then REQ=0001, REQ_DATA[7:0]=0xA5, REQ_PAR=0001, engine raises BUSY 2 cycles after DATA_VALID and holds it 11 cycles -> GNT=0001 and DATA_VALID for 1 cycle with TX_DATA=0xA5, PAR_EN=1; DONE=0001 one cycle after BUSY falls; OWNER=0.
- REQ=1111 held continuously, distinct bytes 0x11/0x22/0x33/0x44 -> grants in order 0,1,2,3,0; TX_DATA follows; exactly one DATA_VALID per frame.
- After requester 2 completes, REQ=0101 -> requester 0 is granted (wrap from pointer 3). After requester 0 completes, REQ=0101 -> requester 2 is granted.
- Engine never raises BUSY, TO_CYCLES=16 -> ERR pulses once 16 cycles after DATA_VALID; no DONE; state returns to IDLE; the next grant goes to w+1.
- BUSY=1 held in IDLE with REQ=0010 -> no GNT or DATA_VALID. BUSY drops -> GNT=0010 on the next cycle.
- RST pulsed low during WAIT_END -> all outputs 0 immediately, no DONE; after release with REQ=1000, requester 3 is granted with the pointer restarted at 0.
